uart_byte_tx: RTL and testbench
===============================

# uart_byte_tx

Serialises the 8-bit byte stream from the `hello` generator into an asynchronous serial line (start bit, 8 data bits LSB first, optional parity, stop bit). It sits directly downstream of `hello`. A small FIFO and a valid/ready handshake decouple the byte rate from the bit rate. Its `tx` output is the pin-level signal observed in simulation dumps.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥ 2.
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_data`  in  8: byte from upstream.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: FIFO can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: frame in progress or FIFO non-empty.

## Operation
- Reset (`rst_n` low, asynchronous):
  - `tx`=1, `busy`=0, `in_ready`=1.
  - FIFO emptied; FSM enters IDLE; baud counter cleared.
- FIFO:
  - `in_ready` = !full, derived from registered state only.
  - A push is refused when full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo `FIFO_DEPTH`; full/empty are distinguished by an extra pointer bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when FIFO is non-empty. The byte is popped into the shift register; the baud counter restarts.
  - START→DATA on bit tick; bit index set to 0.
  - DATA: `tx` = shift[0]; on each tick shift right and increment the index. After index 7 go to PARITY if compiled in, else STOP.
  - PARITY→STOP on tick.
  - STOP→START on tick if the FIFO is non-empty (pop at the same edge; no idle gap), else →IDLE.
- Line levels: START `tx`=0; STOP and IDLE `tx`=1; PARITY `tx`=even parity bit (XOR of the 8 data bits).
- Bit tick: fires when the baud counter reaches `CLKS_PER_BIT-1`, then the counter wraps to 0. The counter is held at 0 in IDLE.
- `busy` = (state != IDLE) || !empty.
- Upstream stall is permitted: while `in_ready`=0, upstream holds `in_data`. No data is lost and no overflow flag exists.

## Timing
- `tx` and `busy` are registered outputs, with no combinational path from `in_*`.
- Push at edge N into an empty FIFO while IDLE: FSM enters START at edge N+1; `tx` falls at N+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- Back-to-back bytes: the next start bit begins at the edge that ends the previous stop bit.
- Reset mid-frame: `tx` returns high immediately and the partial frame is discarded.
- `in_ready` rises the cycle after a pop from a full FIFO.

## Configuration
- `UART_BYTE_TX_PARITY_EN` defined: PARITY state present; even parity bit sent between data and stop; 11-bit frames.
- Not defined: PARITY state and its logic absent; 10-bit frames.

## Structure
- Package `uart_pkg`:
  - FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - Frame constants: `DATA_BITS`=8, `START_LVL`=0, `STOP_LVL`=1.
- Sub-module `uart_baud_gen`:
  - Counter with synchronous restart and enable inputs.
  - Outputs a one-cycle `tick`.
  - Parameterised by `CLKS_PER_BIT`.
- FIFO stays inline.

## Test plan
- Reset release: `tx`=1, `busy`=0, `in_ready`=1 before any input.
- Single byte 0xA5, `CLKS_PER_BIT`=4, parity off:
  - `tx` = 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles.
  - `busy` drops 40 cycles after the start bit.
- Parity on, byte 0x07 (three ones): parity bit = 1; byte 0xA5: parity bit = 0.
- Burst of 6 bytes 0x00–0x05 with `FIFO_DEPTH`=4 and `in_valid` held high:
  - `in_ready` deasserts after 5 accepted (4 queued, 1 shifting).
  - All 6 bytes transmitted in order with no idle gap between frames.
- Assert `rst_n` mid DATA bit 3 of 0xFF:
  - `tx`=1 asynchronously; FIFO empty.
  - After release, a new byte 0x3C is transmitted correctly.
- Push arriving in the same cycle as the last stop-bit tick: next frame starts with no gap and no byte is dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and frame constants for the byte transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter emitting a one-cycle tick every CLKS_PER_BIT enabled cycles
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign tick = en && !restart && (cnt == CW'(CLKS_PER_BIT - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (restart) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: FIFO-buffered 8N1 serialiser; define UART_BYTE_TX_PARITY_EN for an even parity bit (8E1)
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
  logic full, empty, push, pop, tick, tx_n, busy_n;
  logic [7:0] head, shift, shift_n;
  logic [2:0] idx, idx_n;
  state_t state, state_n;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = wr_ptr == rd_ptr;
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign wr_n     = wr_ptr + (AW+1)'(push);
  assign rd_n     = rd_ptr + (AW+1)'(pop);
  // An empty FIFO at the stop-bit tick forwards a simultaneous push straight into the next frame
  assign head     = empty ? in_data : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(state == IDLE),
    .en     (state != IDLE),
    .tick   (tick)
  );
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_n = START;
        shift_n = head;
        pop     = 1'b1;
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (tick) begin
        shift_n = shift >> 1;
        idx_n   = idx + 1'b1;
`ifdef UART_BYTE_TX_PARITY_EN
        if (idx == 3'(DATA_BITS - 1)) state_n = PARITY;
`else
        if (idx == 3'(DATA_BITS - 1)) state_n = STOP;
`endif
      end
`ifdef UART_BYTE_TX_PARITY_EN
      PARITY: if (tick) state_n = STOP;
`endif
      STOP: if (tick) begin
        state_n = (!empty || push) ? START : IDLE;
        shift_n = (!empty || push) ? head : shift;
        pop     = !empty || push;
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef UART_BYTE_TX_PARITY_EN
  logic par, par_n;
  assign par_n = pop ? even_parity(head) : par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else par <= par_n;
  end
  assign tx_n = state_n == START ? START_LVL : state_n == DATA ? shift_n[0] :
                state_n == PARITY ? par_n : STOP_LVL;
`else
  assign tx_n = state_n == START ? START_LVL : state_n == DATA ? shift_n[0] : STOP_LVL;
`endif
  assign busy_n = (state_n != IDLE) || (wr_n != rd_n);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shift  <= '0;
      idx    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx     <= STOP_LVL;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      shift  <= shift_n;
      idx    <= idx_n;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      tx     <= tx_n;
      busy   <= busy_n;
    end
  end
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: scoreboard bench; a line monitor decodes tx and compares each frame with queued bytes
module tb_uart_byte_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_BYTE_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, tx, busy;
  int cyc = 0, errors = 0, checks = 0, frames = 0, exp_frames = 0;
  int accepted = 0, first_stall = -1;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_byte_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Line level of frame bit k for byte b: start, 8 data LSB first, optional even parity, stop
  function automatic logic lvl(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin : frame
        logic [7:0] b;
        bit ok, ab;
        starts.push_back(cyc);
        b = 8'h00;
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else b = exp_q.pop_front();
        ok = 1;
        ab = 0;
        for (int k = 0; k < NB && !ab; k++)
          for (int c = 0; c < CPB && !ab; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (!rst_n) ab = 1;
            else if (tx !== lvl(b, k)) ok = 0;
          end
        if (!ab) begin
          chk($sformatf("frame_%02h", b), ok, 1);
          frames++;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1;
    if (!in_ready && first_stall < 0) first_stall = accepted;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      chk("push_timeout", n, 0);
      in_valid = 0;
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      accepted++;
      exp_frames++;
      @(negedge clk);
      in_valid = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 20000) begin @(negedge clk); n++; end
    chk("drained", n < 20000, 1);
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while (tx !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
  endtask

  task automatic reset_mid(input int offset);
    int n;
    wait_fall(n);
    chk("fall_before_reset", n < 1000, 1);
    repeat (offset) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ready", in_ready, 1);
    exp_frames -= 1 + exp_q.size();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int n, k, s0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", in_ready, 1);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_tx", tx, 1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_ready", in_ready, 1);

    push_byte(8'hA5);
    wait_fall(n);
    chk("start_latency", n, 1);
    k = 0;
    while (busy && k < 1000) begin @(negedge clk); k++; end
    chk("busy_len", k, NB * CPB);
    wait_idle();

`ifdef UART_BYTE_TX_PARITY_EN
    push_byte(8'h07);
    wait_idle();
    push_byte(8'hA5);
    wait_idle();
`endif

    first_stall = -1;
    accepted = 0;
    s0 = starts.size();
    for (int i = 0; i < 6; i++) push_byte(8'(i));
    wait_idle();
    chk("stall_after", first_stall, 5);
    chk("burst_frames", starts.size() - s0, 6);
    for (int i = 1; i < 6 && s0 + i < starts.size(); i++)
      chk($sformatf("burst_gap_%0d", i), starts[s0+i] - starts[s0+i-1], NB * CPB);

    push_byte(8'hFF);
    push_byte(8'h11);
    push_byte(8'h22);
    reset_mid(CPB * 4 + 2);
    s0 = starts.size();
    repeat (3 * NB * CPB) @(negedge clk);
    chk("no_frame_after_reset", starts.size() - s0, 0);
    push_byte(8'h00);
    reset_mid(2);
    push_byte(8'h3C);
    wait_idle();

    s0 = starts.size();
    push_byte(8'h5A);
    wait_fall(n);
    repeat (NB * CPB - 1) @(negedge clk);
    push_byte(8'hC3);
    wait_idle();
    chk("tick_push_frames", starts.size() - s0, 2);
    if (starts.size() - s0 >= 2) chk("tick_push_gap", starts[s0+1] - starts[s0], NB * CPB);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 60)) @(negedge clk);
      push_byte(8'($urandom));
    end
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);
    chk("frames_total", frames, exp_frames);
    chk("final_tx", tx, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
